// File: rtl/gshare_btb_predictor.sv
// Global-history branch predictor: PHT of 2-bit counters plus a tagged direct-mapped BTB.
// Define BP_GSHARE_EN for gshare indexing (PC xor GHR); otherwise the PHT is indexed bimodally.
module gshare_btb_predictor #(
    parameter int HIST_WIDTH      = 10,
    parameter int BTB_INDEX_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] current_pc,
    output logic [31:0] predicted_pc,
    output logic        predict_taken,
    output logic        ready,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic [31:0] update_target,
    input  logic        update_mispredict,
    output logic [31:0] mispredict_count
);
    localparam int TAG_W  = 30 - BTB_INDEX_WIDTH;
    localparam int INIT_W = (HIST_WIDTH > BTB_INDEX_WIDTH) ? HIST_WIDTH : BTB_INDEX_WIDTH;
    localparam int PHT_N  = 1 << HIST_WIDTH;
    localparam int BTB_N  = 1 << BTB_INDEX_WIDTH;

    typedef enum logic {INIT, RUN} state_t;

    state_t                    state_reg;
    logic [INIT_W-1:0]         init_idx_reg;
    logic                      ready_reg;
    logic [31:0]               mispredict_count_reg;
    logic [HIST_WIDTH-1:0]     ghr;

    logic [1:0]                pht        [PHT_N];
    logic                      btb_valid  [BTB_N];
    logic [TAG_W-1:0]          btb_tag    [BTB_N];
    logic [31:0]               btb_target [BTB_N];

    logic                      upd_en;
    logic [HIST_WIDTH-1:0]     upd_pht_idx;
    logic [BTB_INDEX_WIDTH-1:0] upd_btb_idx;
    logic [1:0]                upd_ctr;
    logic [1:0]                ctr_next;
    logic                      pht_in_range;
    logic                      btb_in_range;

    logic [HIST_WIDTH-1:0]     pred_pht_idx;
    logic [BTB_INDEX_WIDTH-1:0] pred_btb_idx;
    logic                      pred_hit;

    // Low PC bits are always zero for word-aligned fetch and are deliberately ignored.
    logic unused_pc_bits;
    assign unused_pc_bits = &{1'b0, current_pc[1:0], update_pc[1:0]};

    assign upd_en = update_valid && (state_reg == RUN);

`ifdef BP_GSHARE_EN
    logic [HIST_WIDTH-1:0] ghr_reg;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ghr_reg <= '0;
        else if (upd_en)
            ghr_reg <= {ghr_reg[HIST_WIDTH-2:0], update_taken};
    end
    assign ghr = ghr_reg;
`else
    assign ghr = '0;
`endif

    // The walk index may be wider than one of the tables; skip writes past its end.
    generate
        if (INIT_W > HIST_WIDTH) begin : g_pht_range
            assign pht_in_range = ~|init_idx_reg[INIT_W-1:HIST_WIDTH];
        end else begin : g_pht_full
            assign pht_in_range = 1'b1;
        end
        if (INIT_W > BTB_INDEX_WIDTH) begin : g_btb_range
            assign btb_in_range = ~|init_idx_reg[INIT_W-1:BTB_INDEX_WIDTH];
        end else begin : g_btb_full
            assign btb_in_range = 1'b1;
        end
    endgenerate

    assign pred_pht_idx  = current_pc[HIST_WIDTH+1:2] ^ ghr;
    assign pred_btb_idx  = current_pc[BTB_INDEX_WIDTH+1:2];
    assign pred_hit      = btb_valid[pred_btb_idx] &&
                           (btb_tag[pred_btb_idx] == current_pc[31:BTB_INDEX_WIDTH+2]);
    assign predict_taken = ready_reg && pred_hit && pht[pred_pht_idx][1];
    assign predicted_pc  = predict_taken ? btb_target[pred_btb_idx] : current_pc + 32'd4;

    assign upd_pht_idx = update_pc[HIST_WIDTH+1:2] ^ ghr;
    assign upd_btb_idx = update_pc[BTB_INDEX_WIDTH+1:2];
    assign upd_ctr     = pht[upd_pht_idx];

    always_comb begin
        ctr_next = upd_ctr;
        if (update_taken) begin
            if (upd_ctr != 2'b11)
                ctr_next = upd_ctr + 2'd1;
        end else if (upd_ctr != 2'b00) begin
            ctr_next = upd_ctr - 2'd1;
        end
    end

    // Table storage has no reset; the INIT walk clears it after every reset.
    always_ff @(posedge clk) begin
        if (state_reg == INIT) begin
            if (pht_in_range)
                pht[init_idx_reg[HIST_WIDTH-1:0]] <= 2'b01;
            if (btb_in_range)
                btb_valid[init_idx_reg[BTB_INDEX_WIDTH-1:0]] <= 1'b0;
        end else if (upd_en) begin
            pht[upd_pht_idx] <= ctr_next;
            if (update_taken) begin
                btb_valid[upd_btb_idx]  <= 1'b1;
                btb_tag[upd_btb_idx]    <= update_pc[31:BTB_INDEX_WIDTH+2];
                btb_target[upd_btb_idx] <= update_target;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg            <= INIT;
            init_idx_reg         <= '0;
            ready_reg            <= 1'b0;
            mispredict_count_reg <= '0;
        end else begin
            unique case (state_reg)
                INIT: begin
                    init_idx_reg <= init_idx_reg + 1'b1;
                    if (&init_idx_reg) begin
                        state_reg <= RUN;
                        ready_reg <= 1'b1;
                    end
                end
                RUN: begin
                    if (update_valid && update_mispredict &&
                        (mispredict_count_reg != 32'hFFFF_FFFF))
                        mispredict_count_reg <= mispredict_count_reg + 32'd1;
                end
                default: state_reg <= INIT;
            endcase
        end
    end

    assign ready            = ready_reg;
    assign mispredict_count = mispredict_count_reg;
endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Randomised self-checking bench for gshare_btb_predictor against a table-level reference model.
module tb_gshare_btb_predictor;
    localparam int HW = 4;
    localparam int BW = 4;
    localparam int D  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] current_pc = 32'h0;
    logic [31:0] predicted_pc;
    logic        predict_taken;
    logic        ready;
    logic        update_valid = 1'b0;
    logic [31:0] update_pc = 32'h0;
    logic        update_taken = 1'b0;
    logic [31:0] update_target = 32'h0;
    logic        update_mispredict = 1'b0;
    logic [31:0] mispredict_count;

    gshare_btb_predictor #(.HIST_WIDTH(HW), .BTB_INDEX_WIDTH(BW)) dut (
        .clk              (clk),
        .rst              (rst),
        .current_pc       (current_pc),
        .predicted_pc     (predicted_pc),
        .predict_taken    (predict_taken),
        .ready            (ready),
        .update_valid     (update_valid),
        .update_pc        (update_pc),
        .update_taken     (update_taken),
        .update_target    (update_target),
        .update_mispredict(update_mispredict),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: plain integer tables.
    int          m_ctr   [16];
    bit          m_valid [16];
    int unsigned m_tag   [16];
    int unsigned m_tgt   [16];
    int unsigned m_ghr;
    int unsigned m_cnt;
    bit          m_ready;
    int          m_walk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            m_ctr[i]   = 1;
            m_valid[i] = 1'b0;
        end
        m_ghr   = 0;
        m_cnt   = 0;
        m_ready = 1'b0;
        m_walk  = 0;
    endfunction

    function automatic int pht_idx(input int unsigned pc);
`ifdef BP_GSHARE_EN
        return int'(((pc >> 2) ^ m_ghr) % 16);
`else
        return int'((pc >> 2) % 16);
`endif
    endfunction

    function automatic void model_edge(input bit v, input bit tk, input bit mp,
                                       input int unsigned upc, input int unsigned tgt);
        int p;
        int b;
        if (m_ready) begin
            if (v) begin
                p = pht_idx(upc);
                b = int'((upc >> 2) % 16);
                m_ctr[p] = tk ? ((m_ctr[p] < 3) ? m_ctr[p] + 1 : 3)
                              : ((m_ctr[p] > 0) ? m_ctr[p] - 1 : 0);
`ifdef BP_GSHARE_EN
                m_ghr = ((m_ghr * 2) + (tk ? 1 : 0)) % 16;
`endif
                if (tk) begin
                    m_valid[b] = 1'b1;
                    m_tag[b]   = upc >> 6;
                    m_tgt[b]   = tgt;
                end
                if (mp && m_cnt != 32'hFFFF_FFFF)
                    m_cnt++;
            end
        end else begin
            m_walk++;
            if (m_walk == D)
                m_ready = 1'b1;
        end
    endfunction

    task automatic check_pred(input string tag);
        int          b;
        bit          t;
        int unsigned pc;
        pc = current_pc;
        b  = int'((pc >> 2) % 16);
        t  = m_ready && m_valid[b] && (m_tag[b] == (pc >> 6)) && (m_ctr[pht_idx(pc)] >= 2);
        chk({tag, "_taken"}, {31'd0, predict_taken}, {31'd0, t});
        chk({tag, "_pc"}, predicted_pc, t ? m_tgt[b] : pc + 32'd4);
    endtask

    // One clock: drive inputs, check the prediction (pre-update state), clock, check state outputs.
    task automatic cycle(input bit v, input bit tk, input bit mp,
                         input logic [31:0] upc, input logic [31:0] tgt, input logic [31:0] cpc);
        current_pc        = cpc;
        update_valid      = v;
        update_taken      = tk;
        update_mispredict = mp;
        update_pc         = upc;
        update_target     = tgt;
        #1;
        check_pred("pred");
        @(posedge clk);
        model_edge(v, tk, mp, upc, tgt);
        #1;
        update_valid = 1'b0;
        chk("ready", {31'd0, ready}, {31'd0, m_ready});
        chk("mcount", mispredict_count, m_cnt);
        $display("cyc cpc=%h upd=%0d upc=%h tk=%0d mp=%0d pred=%h rdy=%0d cnt=%0d",
                 cpc, v, upc, tk, mp, predicted_pc, ready, mispredict_count);
    endtask

    task automatic do_reset(input int n, input logic [31:0] cpc);
        rst          = 1'b0;
        update_valid = 1'b0;
        current_pc   = cpc;
        model_reset();
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_mcount", mispredict_count, 32'd0);
        chk("rst_taken", {31'd0, predict_taken}, 32'd0);
        chk("rst_pc", predicted_pc, cpc + 32'd4);
        repeat (n) @(posedge clk);
        #1;
        chk("rst_hold_ready", {31'd0, ready}, 32'd0);
        rst = 1'b1;
    endtask

    logic [31:0] pool [8];

    task automatic random_phase(input int n);
        bit          v;
        bit          tk;
        logic [31:0] upc;
        logic [31:0] cpc;
        for (int i = 0; i < n; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            tk  = $urandom_range(0, 1) == 1;
            upc = pool[$urandom_range(0, 7)];
            cpc = pool[$urandom_range(0, 7)];
            cycle(v, tk, $urandom_range(0, 1) == 1, upc, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, cpc);
        end
    endtask

    initial begin
        pool[0] = 32'h40;  pool[1] = 32'h440; pool[2] = 32'h8;   pool[3] = 32'h100;
        pool[4] = 32'h204; pool[5] = 32'h3C0; pool[6] = 32'h48;  pool[7] = 32'hFFFF_FFFC;
        #2;
        do_reset(3, 32'h100);

        // Walk: ready rises only after the 16th edge; one mispredicting update mid-walk is dropped.
        for (int k = 1; k <= D; k++)
            cycle(k == 5, 1'b1, k == 5, 32'h40, 32'h80, 32'h100);

        // Aliasing / bimodal hit on 0x40.
        cycle(1'b1, 1'b1, 1'b1, 32'h40, 32'h80, 32'h40);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h40);
        // Second training, then tag mismatch at 0x440.
        cycle(1'b1, 1'b1, 1'b1, 32'h40, 32'h80, 32'h440);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h440);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h40);

        // Saturation at 0x8.
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 1'b0, 1'b0, 32'h8, 32'h20, 32'h8);
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 1'b1, 1'b0, 32'h8, 32'h20, 32'h8);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h8);

        random_phase(250);

        // Mid-run reset: everything returns to reset values and the walk restarts.
        do_reset(2, 32'h40);
        for (int k = 1; k <= D; k++)
            cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, pool[k % 8]);
        for (int i = 0; i < 8; i++)
            cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, pool[i]);

        random_phase(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
